iperm_req_sched: RTL and testbench

//  Two-requester scheduler and pipeline wrapper for the 16-lane x 32-bit inverse permutator.
//  - Arbitrates packets from ports A and B round-robin; a granted packet keeps the grant until its last beat.
//  - Registers the winning beat (data + 68-bit key) into the permutator inputs.
//  - Captures the permuted result in an output register with valid/ready backpressure.
//  - Throughput is 1 beat/cycle.

---
 rtl/iperm_req_sched.sv | 138 +++++++++++++
 tb/tb_iperm_req_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iperm_req_sched.sv
// Two-port round-robin packet scheduler feeding a 16-lane inverse permutator,
// with an input register stage (S1) and an output register stage (S2) under valid/ready.
module iperm_req_sched #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [511:0]     a_dat,
   input  logic [67:0]      a_kp,
   input  logic [TAG_W-1:0] a_tag,
   input  logic             a_last,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [511:0]     b_dat,
   input  logic [67:0]      b_kp,
   input  logic [TAG_W-1:0] b_tag,
   input  logic             b_last,
   output logic [511:0]     p_t_dat,
   output logic [67:0]      p_t_kp,
   input  logic [511:0]     p_i_dat,
   input  logic [3:0]       p_k_ctrl,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [511:0]     o_dat,
   output logic [3:0]       o_kctrl,
   output logic             o_src,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_last,
   output logic [1:0]       gnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

   state_t             state_q, state_d;
   logic               rr_pri_q, rr_pri_d;   // 0 = A has priority, 1 = B
   logic               s1_v_q, s2_v_q;
   logic [511:0]       s1_dat_q;
   logic [67:0]        s1_kp_q;
   logic               s1_src_q, s1_last_q;
   logic [TAG_W-1:0]   s1_tag_q;
   logic [511:0]       s2_dat_q;
   logic [3:0]         s2_kctrl_q;
   logic               s2_src_q, s2_last_q;
   logic [TAG_W-1:0]   s2_tag_q;
   logic               s1_adv, s2_adv, acc_a, acc_b;

   assign s2_adv  = !s2_v_q || o_ready;
   assign s1_adv  = !s1_v_q || s2_adv;
   assign a_ready = gnt[0] && s1_adv;
   assign b_ready = gnt[1] && s1_adv;
   assign acc_a   = a_valid && a_ready;
   assign acc_b   = b_valid && b_ready;

   // Grant is forced to zero during reset so neither port can handshake.
   always_comb begin
      gnt = '0;
      if (!reset) begin
         unique case (state_q)
            IDLE: begin
               if (a_valid && (!b_valid || !rr_pri_q)) gnt = 2'b01;
               else if (b_valid)                       gnt = 2'b10;
            end
            LOCK_A:  gnt = 2'b01;
            LOCK_B:  gnt = 2'b10;
            default: gnt = '0;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_pri_d = rr_pri_q;
      if (acc_a) begin
         state_d = a_last ? IDLE : LOCK_A;
         if (a_last) rr_pri_d = 1'b1;
      end else if (acc_b) begin
         state_d = b_last ? IDLE : LOCK_B;
         if (b_last) rr_pri_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_pri_q   <= 1'b0;
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         s1_dat_q   <= '0;
         s1_kp_q    <= '0;
         s1_src_q   <= 1'b0;
         s1_tag_q   <= '0;
         s1_last_q  <= 1'b0;
         s2_dat_q   <= '0;
         s2_kctrl_q <= '0;
         s2_src_q   <= 1'b0;
         s2_tag_q   <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_pri_q <= rr_pri_d;
         // S1 only reloads on an accepted beat so the permutator inputs stay quiet otherwise.
         if (s1_adv) begin
            s1_v_q <= acc_a || acc_b;
            if (acc_a || acc_b) begin
               s1_dat_q  <= acc_b ? b_dat  : a_dat;
               s1_kp_q   <= acc_b ? b_kp   : a_kp;
               s1_tag_q  <= acc_b ? b_tag  : a_tag;
               s1_last_q <= acc_b ? b_last : a_last;
               s1_src_q  <= acc_b;
            end
         end
         if (s2_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_dat_q   <= p_i_dat;
               s2_kctrl_q <= p_k_ctrl;
               s2_src_q   <= s1_src_q;
               s2_tag_q   <= s1_tag_q;
               s2_last_q  <= s1_last_q;
            end
         end
      end
   end

   assign p_t_dat = s1_dat_q;
   assign p_t_kp  = s1_kp_q;
   assign o_valid = s2_v_q;
   assign o_dat   = s2_dat_q;
   assign o_kctrl = s2_kctrl_q;
   assign o_src   = s2_src_q;
   assign o_tag   = s2_tag_q;
   assign o_last  = s2_last_q;
   assign busy    = s1_v_q || s2_v_q || (state_q != IDLE);

endmodule

// File: tb/tb_iperm_req_sched.sv
// Scoreboard bench for iperm_req_sched: accepted beats push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_iperm_req_sched;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, a_valid, a_ready, a_last, b_valid, b_ready, b_last;
   logic [511:0]     a_dat, b_dat, p_t_dat, p_i_dat, o_dat;
   logic [67:0]      a_kp, b_kp, p_t_kp;
   logic [TAG_W-1:0] a_tag, b_tag, o_tag;
   logic [3:0]       p_k_ctrl, o_kctrl;
   logic             o_valid, o_ready, o_src, o_last, busy;
   logic [1:0]       gnt;

   iperm_req_sched #(.TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_dat(a_dat), .a_kp(a_kp), .a_tag(a_tag), .a_last(a_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_dat(b_dat), .b_kp(b_kp), .b_tag(b_tag), .b_last(b_last),
      .p_t_dat(p_t_dat), .p_t_kp(p_t_kp), .p_i_dat(p_i_dat), .p_k_ctrl(p_k_ctrl),
      .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat), .o_kctrl(o_kctrl),
      .o_src(o_src), .o_tag(o_tag), .o_last(o_last), .gnt(gnt), .busy(busy)
   );

   // Inverse permutator model: output lane n takes input lane sel[n].
   function automatic logic [511:0] perm(input logic [511:0] d, input logic [67:0] k);
      logic [511:0] r;
      r = '0;
      for (int n = 0; n < 16; n++) r[32*n +: 32] = d[32*k[4*n +: 4] +: 32];
      return r;
   endfunction

   assign p_i_dat  = perm(p_t_dat, p_t_kp);
   assign p_k_ctrl = p_t_kp[67:64];

   typedef struct {
      logic [511:0]     dat;
      logic [3:0]       kc;
      logic             src;
      logic [TAG_W-1:0] tag;
      logic             last;
   } item_t;
   typedef struct {
      logic src;
      int   cyc;
   } ev_t;

   item_t        sb[$];
   ev_t          acc_log[$];
   int           out_cyc[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [511:0] last_dat;
   logic         stall_q = 1'b0;
   logic [511:0] prev_dat;
   logic [9:0]   prev_side;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected results come from the stimulus side of each handshake.
   always @(negedge clk) begin
      if (!reset) begin
         chk("ready_exclusive", 512'(a_ready && b_ready), 512'(0));
         if (a_valid && a_ready) begin
            sb.push_back('{perm(a_dat, a_kp), a_kp[67:64], 1'b0, a_tag, a_last});
            acc_log.push_back('{1'b0, cyc});
         end
         if (b_valid && b_ready) begin
            sb.push_back('{perm(b_dat, b_kp), b_kp[67:64], 1'b1, b_tag, b_last});
            acc_log.push_back('{1'b1, cyc});
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_dat", o_dat, prev_dat);
            chk("stall_side", 512'({o_kctrl, o_src, o_tag, o_last}), 512'(prev_side));
            chk("stall_valid", 512'(o_valid), 512'(1));
         end
         if (o_valid && o_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 512'(1), 512'(0));
            end else begin
               item_t e;
               e = sb.pop_front();
               chk("o_dat", o_dat, e.dat);
               chk("o_kctrl", 512'(o_kctrl), 512'(e.kc));
               chk("o_src", 512'(o_src), 512'(e.src));
               chk("o_tag", 512'(o_tag), 512'(e.tag));
               chk("o_last", 512'(o_last), 512'(e.last));
            end
            out_cyc.push_back(cyc);
            last_dat = o_dat;
         end
         stall_q   = o_valid && !o_ready;
         prev_dat  = o_dat;
         prev_side = {o_kctrl, o_src, o_tag, o_last};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic port, input logic [511:0] d, input logic [67:0] k,
                       input logic [TAG_W-1:0] t, input logic l);
      logic done;
      done = 1'b0;
      if (!port) begin
         a_valid = 1'b1; a_dat = d; a_kp = k; a_tag = t; a_last = l;
      end else begin
         b_valid = 1'b1; b_dat = d; b_kp = k; b_tag = t; b_last = l;
      end
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (port ? b_ready : a_ready) done = 1'b1;
         step();
      end
      chk("send_accepted", 512'(done), 512'(1));
      if (!port) a_valid = 1'b0;
      else       b_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) step();
      chk("drain_empty", 512'(sb.size()), 512'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      step();
      reset = 1'b0;
   endtask

   function automatic logic [511:0] rnd_dat();
      logic [511:0] r;
      for (int n = 0; n < 16; n++) r[32*n +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [67:0] rnd_kp();
      logic [67:0] r;
      for (int n = 0; n < 17; n++) r[4*n +: 4] = 4'($urandom_range(15, 0));
      return r;
   endfunction

   task automatic clear_logs();
      acc_log.delete();
      out_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [511:0] d1, hand;
      logic [67:0]  k1;
      logic         pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
      a_dat = '0; a_kp = '0; a_tag = '0; a_last = 1'b0;
      b_dat = '0; b_kp = '0; b_tag = '0; b_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a_valid = 1'b1; b_valid = 1'b1;
      @(negedge clk);
      chk("rst_a_ready", 512'(a_ready), 512'(0));
      chk("rst_b_ready", 512'(b_ready), 512'(0));
      chk("rst_gnt", 512'(gnt), 512'(0));
      chk("rst_o_valid", 512'(o_valid), 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      step();
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      sb.delete();

      // 1: single beat A, lane n = n, select lane n = 15-n
      clear_logs();
      for (int n = 0; n < 16; n++) begin
         d1[32*n +: 32]   = 32'(n);
         k1[4*n +: 4]     = 4'(15 - n);
         hand[32*n +: 32] = 32'(15 - n);
      end
      k1[67:64] = 4'hA;
      send(1'b0, d1, k1, 4'd5, 1'b1);
      for (int i = 0; i < 20 && out_cyc.size() == 0; i++) @(negedge clk);
      chk("t1_out_seen", 512'(out_cyc.size()), 512'(1));
      if (out_cyc.size() > 0 && acc_log.size() > 0)
         chk("t1_latency", 512'(out_cyc[0] - acc_log[0].cyc), 512'(2));
      chk("t1_hand_dat", last_dat, hand);
      step();
      drain();

      // 2: both ports, single-beat packets, alternate A,B,A,B at full rate
      do_reset();
      clear_logs();
      fork
         begin
            for (int i = 0; i < 4; i++) send(1'b0, rnd_dat(), rnd_kp(), 4'(i), 1'b1);
         end
         begin
            for (int i = 0; i < 4; i++) send(1'b1, rnd_dat(), rnd_kp(), 4'(8 + i), 1'b1);
         end
      join
      drain();
      chk("t2_acc_count", 512'(acc_log.size()), 512'(8));
      for (int i = 0; i < acc_log.size(); i++) begin
         chk("t2_order", 512'(acc_log[i].src), 512'(i % 2));
         if (i > 0) chk("t2_rate", 512'(acc_log[i].cyc - acc_log[i-1].cyc), 512'(1));
      end
      for (int i = 1; i < out_cyc.size(); i++)
         chk("t2_out_rate", 512'(out_cyc[i] - out_cyc[i-1]), 512'(1));

      // 3: 4-beat A packet holds the lock while B waits
      clear_logs();
      fork
         begin
            for (int i = 0; i < 4; i++) send(1'b0, rnd_dat(), rnd_kp(), 4'(i), 1'(i == 3));
         end
         send(1'b1, rnd_dat(), rnd_kp(), 4'd9, 1'b1);
      join
      drain();
      chk("t3_acc_count", 512'(acc_log.size()), 512'(5));
      for (int i = 0; i < acc_log.size(); i++) begin
         chk("t3_order", 512'(acc_log[i].src), 512'(i == 4));
         if (i > 0) chk("t3_rate", 512'(acc_log[i].cyc - acc_log[i-1].cyc), 512'(1));
      end

      // 4: A stream under 1,0,0,1 output backpressure
      clear_logs();
      fork
         begin
            for (int i = 0; i < 8; i++) send(1'b0, rnd_dat(), rnd_kp(), 4'(i), 1'(i == 7));
         end
         begin
            for (int i = 0; i < 40; i++) begin
               o_ready = pat[i % 4];
               step();
            end
            o_ready = 1'b1;
         end
      join
      drain();
      chk("t4_out_count", 512'(out_cyc.size()), 512'(8));

      // 5: reset with both stages full in the middle of a 3-beat B packet
      clear_logs();
      o_ready = 1'b0;
      send(1'b1, rnd_dat(), rnd_kp(), 4'd0, 1'b0);
      send(1'b1, rnd_dat(), rnd_kp(), 4'd1, 1'b0);
      b_valid = 1'b1; b_dat = rnd_dat(); b_kp = rnd_kp(); b_tag = 4'd2; b_last = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("t5_full_b_ready", 512'(b_ready), 512'(0));
         chk("t5_lock_gnt", 512'(gnt), 512'(2'b10));
      end
      step();
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("t5_rst_gnt", 512'(gnt), 512'(0));
      chk("t5_rst_b_ready", 512'(b_ready), 512'(0));
      step();
      reset = 1'b0; b_valid = 1'b0; o_ready = 1'b1;
      @(negedge clk);
      chk("t5_o_valid", 512'(o_valid), 512'(0));
      chk("t5_busy", 512'(busy), 512'(0));
      step();
      send(1'b0, rnd_dat(), rnd_kp(), 4'd3, 1'b1);
      chk("t5_acc_count", 512'(acc_log.size()), 512'(3));
      if (acc_log.size() > 0) chk("t5_a_after_reset", 512'(acc_log[acc_log.size()-1].src), 512'(0));
      drain();

      // 6: A idles for 5 cycles inside its lock while B waits
      clear_logs();
      send(1'b0, rnd_dat(), rnd_kp(), 4'd0, 1'b0);
      fork
         send(1'b1, rnd_dat(), rnd_kp(), 4'd9, 1'b1);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("t6_b_ready", 512'(b_ready), 512'(0));
               chk("t6_gnt", 512'(gnt), 512'(2'b01));
            end
            step();
            send(1'b0, rnd_dat(), rnd_kp(), 4'd1, 1'b0);
            send(1'b0, rnd_dat(), rnd_kp(), 4'd2, 1'b1);
         end
      join
      drain();
      chk("t6_acc_count", 512'(acc_log.size()), 512'(4));
      for (int i = 0; i < acc_log.size(); i++)
         chk("t6_order", 512'(acc_log[i].src), 512'(i == 3));

      repeat (3) step();
      chk("final_sb_empty", 512'(sb.size()), 512'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
